// File: rtl/lsu_align.sv
// Load/store alignment unit: byte/half/word accesses at any byte address, word-crossing
// accesses split into two word accesses. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_align #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC1 = 2'd1;
   localparam logic [1:0] S_ACC2 = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       w0_q, w0_d;
   logic [31:0]       w1_q, w1_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              mis;
   logic [3:0]        mask;
   logic [7:0]        lane;
   logic [63:0]       sdata;
   logic [31:0]       raw;
   logic [31:0]       load_data;
   logic [ADDR_W-1:0] word_a;
   logic [ADDR_W-1:0] next_a;

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   assign word_a = {addr_q[ADDR_W-1:2], 2'b00};
   assign next_a = word_a + ADDR_W'(4);

   always_comb begin
      case (size_q)
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      lane  = {4'b0000, mask} << addr_q[1:0];
      sdata = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
      // W1 is zeroed in ACC1, so a skipped ACC2 contributes nothing here
      raw   = 32'({w1_q, w0_q} >> {addr_q[1:0], 3'b000});
      case (size_q)
         2'b00:   load_data = {{24{sgn_q & raw[7]}}, raw[7:0]};
         2'b01:   load_data = {{16{sgn_q & raw[15]}}, raw[15:0]};
         default: load_data = raw;
      endcase
      if (we_q || err_q) load_data = 32'h0;
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sgn_d      = sgn_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      w0_d       = w0_q;
      w1_d       = w1_q;
      rdata_d    = rdata_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_a      = '0;
      mem_wd     = 32'h0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sgn_d   = req_signed;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = mis;
               state_d = mis ? S_RESP : S_ACC1;
            end
         end
         S_ACC1: begin
            mem_a   = word_a;
            mem_be  = lane[3:0];
            mem_wd  = sdata[31:0];
            mem_we  = we_q;
            w0_d    = mem_rd;
            w1_d    = 32'h0;
            state_d = (lane[7:4] != 4'b0000) ? S_ACC2 : S_RESP;
         end
         S_ACC2: begin
            mem_a   = next_a;
            mem_be  = lane[7:4];
            mem_wd  = sdata[63:32];
            mem_we  = we_q;
            w1_d    = mem_rd;
            state_d = S_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            rdata_d    = load_data;
            state_d    = S_IDLE;
         end
      endcase
   end

   // In RESP the fresh result is driven straight through; afterwards the captured copy holds
   assign resp_rdata = (state_q == S_RESP) ? load_data : rdata_q;
   assign resp_err   = (state_q == S_RESP) && err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         w0_q    <= 32'h0;
         w1_q    <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, mid-split reset sequence, and random traffic
// against a byte-addressed reference memory.
module tb_lsu_align;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, reset, req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_wd, mem_rd, mem_a;
   logic        resp_valid, resp_err, mem_we;
   logic [3:0]  mem_be;
   logic        mem_clr;

   lsu_align #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1 KiB data memory; upper address bits alias, consistent with the reference model
   logic [31:0] dmem [256];
   assign mem_rd = dmem[mem_a[9:2]];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      end else if (mem_we) begin
         for (int j = 0; j < 4; j++)
            if (mem_be[j]) dmem[mem_a[9:2]][8*j +: 8] <= mem_wd[8*j +: 8];
      end
   end

   bit [7:0] refm [1024];
   int total = 0;
   int bad = 0;

   bit [31:0] ra [2];
   bit [31:0] rwd [2];
   bit [3:0]  rbe [2];
   bit        rwe [2];
   int        nacc;

   typedef struct {
      bit        we;
      bit [1:0]  sz;
      bit        sg;
      bit [31:0] a;
      bit [31:0] wd;
      bit        hold;
      bit [31:0] exp_rd;
      bit        exp_err;
      int        exp_lat;
      int        exp_nacc;
      bit [31:0] a0;
      bit [3:0]  be0;
      bit [31:0] wd0;
      bit [31:0] a1;
      bit [3:0]  be1;
      bit [31:0] wd1;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int nbytes(bit [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit [31:0] ref_load(bit [31:0] a, bit [1:0] sz, bit sg);
      int n = nbytes(sz);
      bit [31:0] v = 32'h0;
      for (int i = 0; i < n; i++) v |= 32'(refm[10'(a + 32'(i))]) << (8 * i);
      if (sg && n == 1 && v[7])  v |= 32'hFFFF_FF00;
      if (sg && n == 2 && v[15]) v |= 32'hFFFF_0000;
      return v;
   endfunction

   function automatic void ref_store(bit [31:0] a, bit [1:0] sz, bit [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++) refm[10'(a + 32'(i))] = wd[8*i +: 8];
   endfunction

   // Lane j of word wa is enabled when that byte lies inside [a, a+n)
   function automatic bit [3:0] ref_be(bit [31:0] wa, bit [31:0] a, int n);
      bit [3:0] b = 4'b0000;
      for (int j = 0; j < 4; j++) if ((wa + 32'(j) - a) < 32'(n)) b[j] = 1'b1;
      return b;
   endfunction

   // Called at #1 after a clock edge with the DUT idle; returns at #1 after the edge that follows RESP
   task automatic txn(input bit we, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                      input bit [31:0] wd, input bit hold, input bit [31:0] exp_rd,
                      output bit [31:0] rd, output int lat, output bit err);
      bit got = 1'b0;
      bit busy_rdy = 1'b0;
      nacc = 0; rd = 32'h0; err = 1'b0; lat = 0;
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      if (hold) begin
         req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
      end else req_valid = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         lat = c;
         if (req_ready) busy_rdy = 1'b1;
         if (resp_valid) begin
            got = 1'b1; rd = resp_rdata; err = resp_err;
         end else begin
            if (mem_we || mem_be != 4'b0000) begin
               if (nacc < 2) begin
                  ra[nacc] = mem_a; rbe[nacc] = mem_be; rwd[nacc] = mem_wd; rwe[nacc] = mem_we;
               end
               nacc++;
            end
            @(posedge clk); #1;
         end
      end
      req_valid = 1'b0;
      chk("resp_seen", 32'(got), 32'd1);
      chk("ready_busy", 32'(busy_rdy), 32'd0);
      @(posedge clk); #1;
      chk("resp_pulse", 32'(resp_valid), 32'd0);
      chk("rdata_hold", resp_rdata, exp_rd);
   endtask

   initial begin
      bit [31:0] rd;
      int lat;
      bit err;

      for (int i = 0; i < 1024; i++) refm[i] = 8'h00;
      reset = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      reset = 1'b0; mem_clr = 1'b0;
      @(posedge clk); #1;

      //        we sz     sg a             wd            hold exp_rd        err lat nacc a0            be0     wd0           a1            be1     wd1
      vq.push_back('{1, 2'd2, 0, 32'h100,      32'h11223344, 0, 32'h0,        0, 2, 1, 32'h100,      4'b1111, 32'h11223344, 32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd2, 0, 32'h100,      32'h0,        0, 32'h11223344, 0, 2, 1, 32'h100,      4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{1, 2'd0, 0, 32'h103,      32'h000000AB, 0, 32'h0,        0, 2, 1, 32'h100,      4'b1000, 32'hAB000000, 32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd0, 1, 32'h103,      32'h0,        0, 32'hFFFFFFAB, 0, 2, 1, 32'h100,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd0, 0, 32'h103,      32'h0,        0, 32'h000000AB, 0, 2, 1, 32'h100,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd2, 0, 32'h100,      32'h0,        0, 32'hAB223344, 0, 2, 1, 32'h100,      4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{1, 2'd2, 0, 32'h100,      32'h80FF1234, 0, 32'h0,        0, 2, 1, 32'h100,      4'b1111, 32'h80FF1234, 32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd1, 1, 32'h102,      32'h0,        0, 32'hFFFF80FF, 0, 2, 1, 32'h100,      4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd1, 0, 32'h102,      32'h0,        0, 32'h000080FF, 0, 2, 1, 32'h100,      4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{0, 2'd1, 1, 32'h100,      32'h0,        0, 32'h00001234, 0, 2, 1, 32'h100,      4'b0011, 32'h0,        32'h0,        4'b0000, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
      vq.push_back('{0, 2'd2, 0, 32'h202,      32'h0,        0, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0});
      vq.push_back('{1, 2'd1, 0, 32'h101,      32'h5555,     1, 32'h0,        1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0});
`else
      vq.push_back('{1, 2'd2, 0, 32'h201,      32'hDEADBEEF, 1, 32'h0,        0, 3, 2, 32'h200,      4'b1110, 32'hADBEEF00, 32'h204,      4'b0001, 32'h000000DE});
      vq.push_back('{0, 2'd2, 0, 32'h201,      32'h0,        0, 32'hDEADBEEF, 0, 3, 2, 32'h200,      4'b1110, 32'h0,        32'h204,      4'b0001, 32'h0});
      vq.push_back('{1, 2'd1, 0, 32'hFFFFFFFF, 32'h0000CAFE, 0, 32'h0,        0, 3, 2, 32'hFFFFFFFC, 4'b1000, 32'hFE000000, 32'h0,        4'b0001, 32'h000000CA});
      vq.push_back('{0, 2'd1, 1, 32'hFFFFFFFF, 32'h0,        0, 32'hFFFFCAFE, 0, 3, 2, 32'hFFFFFFFC, 4'b1000, 32'h0,        32'h0,        4'b0001, 32'h0});
`endif

      foreach (vq[k]) begin
         txn(vq[k].we, vq[k].sz, vq[k].sg, vq[k].a, vq[k].wd, vq[k].hold, vq[k].exp_rd, rd, lat, err);
         chk($sformatf("v%0d_rdata", k), rd, vq[k].exp_rd);
         chk($sformatf("v%0d_err", k), 32'(err), 32'(vq[k].exp_err));
         chk($sformatf("v%0d_lat", k), 32'(lat), 32'(vq[k].exp_lat));
         chk($sformatf("v%0d_nacc", k), 32'(nacc), 32'(vq[k].exp_nacc));
         if (vq[k].exp_nacc >= 1 && nacc >= 1) begin
            chk($sformatf("v%0d_acc1", k), {rwe[0], 27'h0, rbe[0]}, {vq[k].we, 27'h0, vq[k].be0});
            chk($sformatf("v%0d_a0", k), ra[0], vq[k].a0);
            chk($sformatf("v%0d_wd0", k), rwd[0], vq[k].wd0);
         end
         if (vq[k].exp_nacc == 2 && nacc == 2) begin
            chk($sformatf("v%0d_acc2", k), {rwe[1], 27'h0, rbe[1]}, {vq[k].we, 27'h0, vq[k].be1});
            chk($sformatf("v%0d_a1", k), ra[1], vq[k].a1);
            chk($sformatf("v%0d_wd1", k), rwd[1], vq[k].wd1);
         end
         if (vq[k].we && !vq[k].exp_err) ref_store(vq[k].a, vq[k].sz, vq[k].wd);
      end

      // Reset in the middle of a store: the write enable must fall with reset, nothing answers
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_wdata = 32'h12345678;
      req_addr = TRAP ? 32'h300 : 32'h301;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!TRAP) begin
         @(posedge clk); #1;
         ref_store(32'h301, 2'd0, 32'h78);
         ref_store(32'h302, 2'd0, 32'h56);
         ref_store(32'h303, 2'd0, 32'h34);
      end
      chk("mid_we_before", 32'(mem_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_we_drop", {27'h0, mem_we, mem_be}, 32'h0);
      @(posedge clk); #1;
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_no_resp2", 32'(resp_valid), 32'd0);
      chk("mid_ready", 32'(req_ready), 32'd1);
      chk("mid_rdata", resp_rdata, 32'h0);

      for (int t = 0; t < 200; t++) begin
         bit we, sg, mis, split, e_err;
         bit [1:0] sz;
         bit [31:0] a, wd, wa, e_rd;
         int n, e_lat, e_nacc;
         we = 1'(($urandom_range(0, 1)));
         sg = 1'(($urandom_range(0, 1)));
         sz = 2'($urandom_range(0, 3));
         wd = $urandom;
         a  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) a |= 32'hFFFF_FC00;
         n     = nbytes(sz);
         mis   = (a % 32'(n)) != 0;
         split = (32'(a % 4) + 32'(n)) > 4;
         e_err = TRAP && mis;
         e_rd  = (we || e_err) ? 32'h0 : ref_load(a, sz, sg);
         e_lat = e_err ? 1 : (split ? 3 : 2);
         e_nacc = e_err ? 0 : (split ? 2 : 1);
         wa = a & 32'hFFFF_FFFC;
         txn(we, sz, sg, a, wd, 1'(t % 5 == 0), e_rd, rd, lat, err);
         chk("rnd_rdata", rd, e_rd);
         chk("rnd_err", 32'(err), 32'(e_err));
         chk("rnd_lat", 32'(lat), 32'(e_lat));
         chk("rnd_nacc", 32'(nacc), 32'(e_nacc));
         if (e_nacc >= 1 && nacc >= 1) begin
            chk("rnd_a0", ra[0], wa);
            chk("rnd_be0", {rwe[0], 27'h0, rbe[0]}, {we, 27'h0, ref_be(wa, a, n)});
         end
         if (e_nacc == 2 && nacc == 2) begin
            chk("rnd_a1", ra[1], wa + 32'd4);
            chk("rnd_be1", {rwe[1], 27'h0, rbe[1]}, {we, 27'h0, ref_be(wa + 32'd4, a, n)});
         end
         if (we && !e_err) ref_store(a, sz, wd);
      end

      begin
         int diffs = 0;
         for (int w = 0; w < 256; w++)
            for (int j = 0; j < 4; j++)
               if (dmem[w][8*j +: 8] !== refm[4*w + j]) diffs++;
         chk("mem_final_diffs", 32'(diffs), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
